// File: rtl/ibex_mem_port_arbiter_if.sv
// Signal bundle for the shared memory port arbiter: fetch, data and bus sides.
// slave is the arbiter view; master is the core/memory environment view.
interface ibex_mem_port_arbiter_if;
    logic        instr_req_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_addr_i;
    logic [31:0] instr_rdata_o;
    logic [6:0]  instr_rdata_intg_o;
    logic        instr_err_o;

    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [6:0]  data_wdata_intg_i;
    logic [31:0] data_rdata_o;
    logic [6:0]  data_rdata_intg_o;
    logic        data_err_o;

    logic        bus_req_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic        bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [6:0]  bus_wdata_intg_o;
    logic [31:0] bus_rdata_i;
    logic [6:0]  bus_rdata_intg_i;
    logic        bus_err_i;

    modport slave (
        input  instr_req_i,
        input  instr_addr_i,
        output instr_gnt_o,
        output instr_rvalid_o,
        output instr_rdata_o,
        output instr_rdata_intg_o,
        output instr_err_o,
        input  data_req_i,
        input  data_we_i,
        input  data_be_i,
        input  data_addr_i,
        input  data_wdata_i,
        input  data_wdata_intg_i,
        output data_gnt_o,
        output data_rvalid_o,
        output data_rdata_o,
        output data_rdata_intg_o,
        output data_err_o,
        output bus_req_o,
        output bus_we_o,
        output bus_be_o,
        output bus_addr_o,
        output bus_wdata_o,
        output bus_wdata_intg_o,
        input  bus_gnt_i,
        input  bus_rvalid_i,
        input  bus_rdata_i,
        input  bus_rdata_intg_i,
        input  bus_err_i
    );

    modport master (
        output instr_req_i,
        output instr_addr_i,
        input  instr_gnt_o,
        input  instr_rvalid_o,
        input  instr_rdata_o,
        input  instr_rdata_intg_o,
        input  instr_err_o,
        output data_req_i,
        output data_we_i,
        output data_be_i,
        output data_addr_i,
        output data_wdata_i,
        output data_wdata_intg_i,
        input  data_gnt_o,
        input  data_rvalid_o,
        input  data_rdata_o,
        input  data_rdata_intg_o,
        input  data_err_o,
        input  bus_req_o,
        input  bus_we_o,
        input  bus_be_o,
        input  bus_addr_o,
        input  bus_wdata_o,
        input  bus_wdata_intg_o,
        output bus_gnt_i,
        output bus_rvalid_i,
        output bus_rdata_i,
        output bus_rdata_intg_i,
        output bus_err_i
    );
endinterface

// File: rtl/ibex_mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between fetch and load/store.
// Define IBEX_MEM_ARB_RR_EN for round-robin instead of data-first priority.
module ibex_mem_port_arbiter #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ibex_mem_port_arbiter_if.slave mem,
    output logic [3:0]            outstanding_o,
    output logic                  spurious_rvalid_o
);

    localparam int unsigned PtrW =
        (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [3:0] Depth = 4'(MaxOutstanding);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

    localparam logic SrcInstr = 1'b0;
    localparam logic SrcData  = 1'b1;

    typedef enum logic [1:0] {
        ArbFree  = 2'd0,
        ArbLockI = 2'd1,
        ArbLockD = 2'd2
    } arb_state_e;

    arb_state_e state_q, state_d;

    logic [MaxOutstanding-1:0] id_q;
    logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [3:0]                count_q, count_d;
    logic                      spurious_q;

    logic sel, sel_req, pick_both;
    logic both_req, locked;
    logic full, empty;
    logic bus_req, push, pop, head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

`ifdef IBEX_MEM_ARB_RR_EN
    logic last_q;

    // The requester that did not win the previous handshake goes next.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= SrcInstr;
        end else if (push) begin
            last_q <= sel;
        end
    end

    assign pick_both = ~last_q;
`else
    assign pick_both = SrcData;
`endif

    assign both_req = mem.instr_req_i & mem.data_req_i;
    assign locked   = (state_q != ArbFree);

    always_comb begin
        sel = SrcData;
        unique case (1'b1)
            state_q == ArbLockI:                   sel = SrcInstr;
            state_q == ArbLockD:                   sel = SrcData;
            !locked && both_req:                   sel = pick_both;
            !locked && !both_req && mem.instr_req_i: sel = SrcInstr;
            default:                               sel = SrcData;
        endcase
    end

    assign full    = (count_q == Depth);
    assign empty   = (count_q == 4'd0);
    assign sel_req = sel ? mem.data_req_i : mem.instr_req_i;
    assign bus_req = sel_req & ~full;
    assign push    = bus_req & mem.bus_gnt_i;
    assign pop     = mem.bus_rvalid_i & ~empty;
    assign head    = id_q[rd_ptr_q];

    // Hold the owner while its request is out on the bus ungranted.
    always_comb begin
        state_d = ArbFree;
        if (bus_req && !mem.bus_gnt_i) begin
            state_d = sel ? ArbLockD : ArbLockI;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ArbFree;
            count_q    <= 4'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (mem.bus_rvalid_i && empty) begin
                spurious_q <= 1'b1;
            end
        end
    end

    // Entry contents are only read once counted valid, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_q[wr_ptr_q] <= sel;
        end
    end

    always_comb begin
        mem.bus_we_o         = 1'b0;
        mem.bus_be_o         = 4'hF;
        mem.bus_addr_o       = mem.instr_addr_i;
        mem.bus_wdata_o      = 32'h0;
        mem.bus_wdata_intg_o = 7'h0;
        if (sel == SrcData) begin
            mem.bus_we_o         = mem.data_we_i;
            mem.bus_be_o         = mem.data_be_i;
            mem.bus_addr_o       = mem.data_addr_i;
            mem.bus_wdata_o      = mem.data_wdata_i;
            mem.bus_wdata_intg_o = mem.data_wdata_intg_i;
        end
    end

    assign mem.bus_req_o = bus_req;

    assign mem.instr_gnt_o = push & (sel == SrcInstr);
    assign mem.data_gnt_o  = push & (sel == SrcData);

    assign mem.instr_rvalid_o = pop & (head == SrcInstr);
    assign mem.data_rvalid_o  = pop & (head == SrcData);

    assign mem.instr_rdata_o      = mem.bus_rdata_i;
    assign mem.instr_rdata_intg_o = mem.bus_rdata_intg_i;
    assign mem.instr_err_o        = mem.bus_err_i;
    assign mem.data_rdata_o       = mem.bus_rdata_i;
    assign mem.data_rdata_intg_o  = mem.bus_rdata_intg_i;
    assign mem.data_err_o         = mem.bus_err_i;

    assign outstanding_o     = count_q;
    assign spurious_rvalid_o = spurious_q;

endmodule

// File: tb/tb_ibex_mem_port_arbiter.sv
// Directed bench for ibex_mem_port_arbiter with MaxOutstanding=2.
// Expectations follow the build: round-robin when IBEX_MEM_ARB_RR_EN is set.
module tb_ibex_mem_port_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] outstanding;
    logic       spurious;
    int         total;
    int         bad;

    ibex_mem_port_arbiter_if bi();

    ibex_mem_port_arbiter #(.MaxOutstanding(2)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .mem              (bi),
        .outstanding_o    (outstanding),
        .spurious_rvalid_o(spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bi.instr_req_i       = 1'b0;
        bi.instr_addr_i      = 32'h0;
        bi.data_req_i        = 1'b0;
        bi.data_we_i         = 1'b0;
        bi.data_be_i         = 4'h0;
        bi.data_addr_i       = 32'h0;
        bi.data_wdata_i      = 32'h0;
        bi.data_wdata_intg_i = 7'h0;
        bi.bus_gnt_i         = 1'b0;
        bi.bus_rvalid_i      = 1'b0;
        bi.bus_rdata_i       = 32'h0;
        bi.bus_rdata_intg_i  = 7'h0;
        bi.bus_err_i         = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (outstanding !== 4'd0) begin
            bad++;
            $display("FAIL reset_outstanding got=%0d want=0", outstanding);
        end
        total++;
        if (spurious !== 1'b0) begin
            bad++;
            $display("FAIL reset_spurious got=%b want=0", spurious);
        end
        total++;
        if ({bi.instr_gnt_o, bi.data_gnt_o, bi.instr_rvalid_o,
             bi.data_rvalid_o, bi.bus_req_o} !== 5'b0) begin
            bad++;
            $display("FAIL reset_handshake got=%b want=00000",
                     {bi.instr_gnt_o, bi.data_gnt_o, bi.instr_rvalid_o,
                      bi.data_rvalid_o, bi.bus_req_o});
        end
    endtask

    task automatic test_single_fetch();
        bi.instr_req_i  = 1'b1;
        bi.instr_addr_i = 32'h100;
        #1;
        total++;
        if ({bi.bus_req_o, bi.bus_we_o, bi.bus_be_o} !== 6'b1_0_1111) begin
            bad++;
            $display("FAIL fetch_ctrl got=%b want=101111",
                     {bi.bus_req_o, bi.bus_we_o, bi.bus_be_o});
        end
        total++;
        if (bi.bus_addr_o !== 32'h100 || bi.instr_gnt_o !== 1'b0) begin
            bad++;
            $display("FAIL fetch_addr got=%h/%b want=00000100/0",
                     bi.bus_addr_o, bi.instr_gnt_o);
        end
        tick();
        bi.bus_gnt_i = 1'b1;
        #1;
        total++;
        if ({bi.instr_gnt_o, bi.data_gnt_o} !== 2'b10) begin
            bad++;
            $display("FAIL fetch_gnt got=%b want=10",
                     {bi.instr_gnt_o, bi.data_gnt_o});
        end
        tick();
        bi.instr_req_i = 1'b0;
        bi.bus_gnt_i   = 1'b0;
        #1;
        total++;
        if (outstanding !== 4'd1 || bi.instr_gnt_o !== 1'b0) begin
            bad++;
            $display("FAIL fetch_wait got=%0d/%b want=1/0",
                     outstanding, bi.instr_gnt_o);
        end
        tick();
        bi.bus_rvalid_i = 1'b1;
        bi.bus_rdata_i  = 32'hDEADBEEF;
        #1;
        total++;
        if ({bi.instr_rvalid_o, bi.data_rvalid_o} !== 2'b10 ||
            bi.instr_rdata_o !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL fetch_resp got=%b/%h want=10/deadbeef",
                     {bi.instr_rvalid_o, bi.data_rvalid_o}, bi.instr_rdata_o);
        end
        tick();
        idle();
        #1;
        total++;
        if (outstanding !== 4'd0) begin
            bad++;
            $display("FAIL fetch_drain got=%0d want=0", outstanding);
        end
    endtask

    task automatic test_contention();
        logic exp_d [4];
`ifdef IBEX_MEM_ARB_RR_EN
        exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        bi.instr_req_i       = 1'b1;
        bi.instr_addr_i      = 32'h104;
        bi.data_req_i        = 1'b1;
        bi.data_we_i         = 1'b1;
        bi.data_be_i         = 4'h3;
        bi.data_addr_i       = 32'h3000;
        bi.data_wdata_i      = 32'h12345678;
        bi.data_wdata_intg_i = 7'h55;
        bi.bus_gnt_i         = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bi.bus_rvalid_i = (k > 0);
            #1;
            total++;
            if ({bi.data_gnt_o, bi.instr_gnt_o} !== {exp_d[k], !exp_d[k]}) begin
                bad++;
                $display("FAIL cont_gnt%0d got=%b want=%b", k,
                         {bi.data_gnt_o, bi.instr_gnt_o},
                         {exp_d[k], !exp_d[k]});
            end
            total++;
            if (bi.bus_addr_o !== (exp_d[k] ? 32'h3000 : 32'h104) ||
                bi.bus_we_o !== exp_d[k]) begin
                bad++;
                $display("FAIL cont_mux%0d got=%h/%b want_data=%b", k,
                         bi.bus_addr_o, bi.bus_we_o, exp_d[k]);
            end
            if (k > 0) begin
                total++;
                if (bi.data_rvalid_o !== exp_d[k-1]) begin
                    bad++;
                    $display("FAIL cont_rv%0d got=%b want=%b", k,
                             bi.data_rvalid_o, exp_d[k-1]);
                end
            end
            if (exp_d[k]) begin
                total++;
                if (bi.bus_wdata_o !== 32'h12345678 ||
                    bi.bus_wdata_intg_o !== 7'h55 || bi.bus_be_o !== 4'h3) begin
                    bad++;
                    $display("FAIL cont_wdata%0d got=%h/%h/%h", k,
                             bi.bus_wdata_o, bi.bus_wdata_intg_o, bi.bus_be_o);
                end
            end
            tick();
        end
        bi.data_req_i = 1'b0;
        #1;
        total++;
        if (bi.instr_gnt_o !== 1'b1 || bi.data_rvalid_o !== exp_d[3]) begin
            bad++;
            $display("FAIL cont_instr got=%b/%b want=1/%b",
                     bi.instr_gnt_o, bi.data_rvalid_o, exp_d[3]);
        end
        tick();
        bi.instr_req_i = 1'b0;
        bi.bus_gnt_i   = 1'b0;
        #1;
        total++;
        if (bi.instr_rvalid_o !== 1'b1) begin
            bad++;
            $display("FAIL cont_last_rv got=%b want=1", bi.instr_rvalid_o);
        end
        tick();
        idle();
        #1;
        total++;
        if (outstanding !== 4'd0) begin
            bad++;
            $display("FAIL cont_drain got=%0d want=0", outstanding);
        end
    endtask

    task automatic test_lock();
        bi.data_req_i  = 1'b1;
        bi.data_addr_i = 32'h2000;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (bi.bus_addr_o !== 32'h2000 || bi.bus_req_o !== 1'b1) begin
                bad++;
                $display("FAIL lock_hold%0d got=%h/%b want=00002000/1", k,
                         bi.bus_addr_o, bi.bus_req_o);
            end
            tick();
        end
        bi.instr_req_i  = 1'b1;
        bi.instr_addr_i = 32'h108;
        #1;
        total++;
        if (bi.bus_addr_o !== 32'h2000 ||
            {bi.instr_gnt_o, bi.data_gnt_o} !== 2'b00) begin
            bad++;
            $display("FAIL lock_irise got=%h/%b want=00002000/00",
                     bi.bus_addr_o, {bi.instr_gnt_o, bi.data_gnt_o});
        end
        tick();
        bi.bus_gnt_i = 1'b1;
        #1;
        total++;
        if ({bi.data_gnt_o, bi.instr_gnt_o} !== 2'b10 ||
            bi.bus_addr_o !== 32'h2000) begin
            bad++;
            $display("FAIL lock_dgnt got=%b/%h want=10/00002000",
                     {bi.data_gnt_o, bi.instr_gnt_o}, bi.bus_addr_o);
        end
        tick();
        bi.data_req_i = 1'b0;
        #1;
        total++;
        if (bi.instr_gnt_o !== 1'b1 || bi.bus_addr_o !== 32'h108) begin
            bad++;
            $display("FAIL lock_igrant got=%b/%h want=1/00000108",
                     bi.instr_gnt_o, bi.bus_addr_o);
        end
        tick();
        bi.instr_req_i  = 1'b0;
        bi.bus_gnt_i    = 1'b0;
        bi.bus_rvalid_i = 1'b1;
        #1;
        total++;
        if ({bi.data_rvalid_o, bi.instr_rvalid_o} !== 2'b10) begin
            bad++;
            $display("FAIL lock_rv1 got=%b want=10",
                     {bi.data_rvalid_o, bi.instr_rvalid_o});
        end
        tick();
        #1;
        total++;
        if ({bi.data_rvalid_o, bi.instr_rvalid_o} !== 2'b01) begin
            bad++;
            $display("FAIL lock_rv2 got=%b want=01",
                     {bi.data_rvalid_o, bi.instr_rvalid_o});
        end
        tick();
        bi.bus_rvalid_i = 1'b0;
        bi.instr_req_i  = 1'b1;
        bi.instr_addr_i = 32'h400;
        tick();
        bi.data_req_i  = 1'b1;
        bi.data_addr_i = 32'h2004;
        #1;
        total++;
        if (bi.bus_addr_o !== 32'h400 || bi.data_gnt_o !== 1'b0) begin
            bad++;
            $display("FAIL lock_iown got=%h/%b want=00000400/0",
                     bi.bus_addr_o, bi.data_gnt_o);
        end
        tick();
        bi.bus_gnt_i = 1'b1;
        #1;
        total++;
        if ({bi.instr_gnt_o, bi.data_gnt_o} !== 2'b10) begin
            bad++;
            $display("FAIL lock_iwins got=%b want=10",
                     {bi.instr_gnt_o, bi.data_gnt_o});
        end
        tick();
        bi.instr_req_i = 1'b0;
        #1;
        total++;
        if (bi.data_gnt_o !== 1'b1 || bi.bus_addr_o !== 32'h2004) begin
            bad++;
            $display("FAIL lock_dnext got=%b/%h want=1/00002004",
                     bi.data_gnt_o, bi.bus_addr_o);
        end
        tick();
        bi.data_req_i   = 1'b0;
        bi.bus_gnt_i    = 1'b0;
        bi.bus_rvalid_i = 1'b1;
        #1;
        total++;
        if ({bi.instr_rvalid_o, bi.data_rvalid_o} !== 2'b10) begin
            bad++;
            $display("FAIL lock_rv3 got=%b want=10",
                     {bi.instr_rvalid_o, bi.data_rvalid_o});
        end
        tick();
        #1;
        total++;
        if ({bi.instr_rvalid_o, bi.data_rvalid_o} !== 2'b01) begin
            bad++;
            $display("FAIL lock_rv4 got=%b want=01",
                     {bi.instr_rvalid_o, bi.data_rvalid_o});
        end
        tick();
        idle();
    endtask

    task automatic test_full_stall();
        bi.instr_req_i  = 1'b1;
        bi.instr_addr_i = 32'h500;
        bi.bus_gnt_i    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++;
            if (bi.instr_gnt_o !== 1'b1) begin
                bad++;
                $display("FAIL full_gnt%0d got=%b want=1", k, bi.instr_gnt_o);
            end
            tick();
        end
        #1;
        total++;
        if (outstanding !== 4'd2 || bi.bus_req_o !== 1'b0) begin
            bad++;
            $display("FAIL full_block got=%0d/%b want=2/0",
                     outstanding, bi.bus_req_o);
        end
        tick();
        bi.bus_rvalid_i = 1'b1;
        #1;
        total++;
        if ({bi.bus_req_o, bi.instr_gnt_o, bi.instr_rvalid_o} !== 3'b001) begin
            bad++;
            $display("FAIL full_rvcycle got=%b want=001",
                     {bi.bus_req_o, bi.instr_gnt_o, bi.instr_rvalid_o});
        end
        tick();
        bi.bus_rvalid_i = 1'b0;
        #1;
        total++;
        if (outstanding !== 4'd1 || bi.instr_gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL full_reopen got=%0d/%b want=1/1",
                     outstanding, bi.instr_gnt_o);
        end
        tick();
        bi.instr_req_i = 1'b0;
        bi.bus_gnt_i   = 1'b0;
        #1;
        total++;
        if (outstanding !== 4'd2) begin
            bad++;
            $display("FAIL full_refill got=%0d want=2", outstanding);
        end
        bi.bus_rvalid_i = 1'b1;
        tick();
        tick();
        idle();
        #1;
        total++;
        if (outstanding !== 4'd0) begin
            bad++;
            $display("FAIL full_drain got=%0d want=0", outstanding);
        end
    endtask

    task automatic test_order_err();
        bi.instr_req_i  = 1'b1;
        bi.instr_addr_i = 32'h600;
        bi.bus_gnt_i    = 1'b1;
        #1;
        total++;
        if (bi.instr_gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL order_igrant got=%b want=1", bi.instr_gnt_o);
        end
        tick();
        bi.instr_req_i = 1'b0;
        bi.data_req_i  = 1'b1;
        bi.data_addr_i = 32'h604;
        #1;
        total++;
        if (bi.data_gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL order_dgrant got=%b want=1", bi.data_gnt_o);
        end
        tick();
        bi.data_req_i       = 1'b0;
        bi.bus_gnt_i        = 1'b0;
        bi.bus_rvalid_i     = 1'b1;
        bi.bus_err_i        = 1'b1;
        bi.bus_rdata_i      = 32'hCAFE0001;
        bi.bus_rdata_intg_i = 7'h2A;
        #1;
        total++;
        if ({bi.instr_rvalid_o, bi.instr_err_o, bi.data_rvalid_o,
             bi.data_err_o} !== 4'b1101) begin
            bad++;
            $display("FAIL order_first got=%b want=1101",
                     {bi.instr_rvalid_o, bi.instr_err_o, bi.data_rvalid_o,
                      bi.data_err_o});
        end
        total++;
        if (bi.instr_rdata_o !== 32'hCAFE0001 ||
            bi.instr_rdata_intg_o !== 7'h2A) begin
            bad++;
            $display("FAIL order_idata got=%h/%h want=cafe0001/2a",
                     bi.instr_rdata_o, bi.instr_rdata_intg_o);
        end
        tick();
        bi.bus_err_i        = 1'b0;
        bi.bus_rdata_i      = 32'hCAFE0002;
        bi.bus_rdata_intg_i = 7'h13;
        #1;
        total++;
        if ({bi.instr_rvalid_o, bi.data_rvalid_o, bi.data_err_o} !== 3'b010) begin
            bad++;
            $display("FAIL order_second got=%b want=010",
                     {bi.instr_rvalid_o, bi.data_rvalid_o, bi.data_err_o});
        end
        total++;
        if (bi.data_rdata_o !== 32'hCAFE0002 ||
            bi.data_rdata_intg_o !== 7'h13) begin
            bad++;
            $display("FAIL order_ddata got=%h/%h want=cafe0002/13",
                     bi.data_rdata_o, bi.data_rdata_intg_o);
        end
        tick();
        idle();
    endtask

    task automatic test_reset_spurious();
        bi.instr_req_i  = 1'b1;
        bi.instr_addr_i = 32'h700;
        bi.bus_gnt_i    = 1'b1;
        tick();
        idle();
        #1;
        total++;
        if (outstanding !== 4'd1) begin
            bad++;
            $display("FAIL spur_pre got=%0d want=1", outstanding);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (outstanding !== 4'd0 || spurious !== 1'b0) begin
            bad++;
            $display("FAIL spur_rst got=%0d/%b want=0/0", outstanding, spurious);
        end
        bi.bus_rvalid_i = 1'b1;
        #1;
        total++;
        if ({bi.instr_rvalid_o, bi.data_rvalid_o} !== 2'b00) begin
            bad++;
            $display("FAIL spur_rv got=%b want=00",
                     {bi.instr_rvalid_o, bi.data_rvalid_o});
        end
        tick();
        bi.bus_rvalid_i = 1'b0;
        tick();
        total++;
        if (spurious !== 1'b1 || outstanding !== 4'd0) begin
            bad++;
            $display("FAIL spur_flag got=%b/%0d want=1/0", spurious, outstanding);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        test_reset();
        test_single_fetch();
        test_contention();
        test_lock();
        test_full_stall();
        test_order_err();
        test_reset_spurious();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
